// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and
// the default geometry of the 8x16 register file it reads.
package regfile_dump_reader_pkg;

  localparam int DEFAULT_NREGS  = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dumpState_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks every regfile address through one read port and streams the values
// out on a valid/ready interface, holding freeze so the snapshot is stable.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] readAddr,
  input  logic [DATA_W-1:0] readData,
  output logic              freeze,
  output logic              busy,
  output logic              done,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [ADDR_W-1:0] outAddr,
  output logic              outLast
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  dumpState_t        state, stateNext;
  logic [ADDR_W-1:0] idx, idxNext;
  logic              outValidNext, outLastNext;
  logic [DATA_W-1:0] outDataNext;
  logic [ADDR_W-1:0] outAddrNext;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outAddr  <= '0;
      outLast  <= 1'b0;
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      outValid <= outValidNext;
      outData  <= outDataNext;
      outAddr  <= outAddrNext;
      outLast  <= outLastNext;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    stateNext    = state;
    idxNext      = idx;
    outValidNext = outValid;
    outDataNext  = outData;
    outAddrNext  = outAddr;
    outLastNext  = outLast;
    readAddr     = '0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          stateNext = FETCH;
          idxNext   = '0;
        end
      end
      FETCH: begin
        readAddr     = idx;
        outDataNext  = readData;
        outAddrNext  = idx;
        outLastNext  = (idx == LAST_IDX);
        outValidNext = 1'b1;
        stateNext    = SEND;
      end
      SEND: begin
        if (outValid && outReady) begin
          outValidNext = 1'b0;
          if (outLast) begin
            stateNext = DONE;
          end else begin
            idxNext   = idx + ADDR_W'(1);
            stateNext = FETCH;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Abort overrides whatever the state logic decided, including a handshake.
    if (abort && (state != IDLE)) begin
      stateNext    = IDLE;
      outValidNext = 1'b0;
      outLastNext  = 1'b0;
    end
  end

  assign busy   = (state != IDLE);
  assign freeze = (state != IDLE);
  assign done   = (state == DONE);

endmodule
